// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared definitions for the iterative restoring divider: FSM state
//   encodings and the enum type the top-level FSM is built on.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

   // Raw 2-bit encodings, kept as localparams so other blocks in the
   // arithmetic datapath can decode the divider state without the enum type.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      DONE = ST_DONE
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   Combinational restoring-division step. Forms the partial remainder
//   {rem, q_msb} (WIDTH+1 bits), trial-subtracts {1'b0, div} and either keeps
//   the difference (quotient bit 1) or restores the shifted remainder
//   (quotient bit 0).
// Ports:
//   rem       in   WIDTH  current remainder
//   q_msb     in   1      next dividend bit shifted in from the Q register
//   div       in   WIDTH  divisor
//   rem_next  out  WIDTH  remainder after this step
//   q_bit     out  1      quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] div,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0]   partial;
   logic [WIDTH-1:0] div_n;
   logic [WIDTH-1:0] diff;
   logic [WIDTH:0]   carry;

   assign partial  = {rem, q_msb};
   assign div_n    = ~div;
   assign carry[0] = 1'b1;

   // Subtract as partial + ~div + 1 over the low WIDTH bits.
   for (genvar i = 0; i < WIDTH; i++) begin : g_rca
      full_adder u_fa (
         .a    (partial[i]),
         .b    (div_n[i]),
         .cin  (carry[i]),
         .s    (diff[i]),
         .cout (carry[i+1])
      );
   end

   // Top bit of the WIDTH+1-bit subtract: the extended divisor bit is 0
   // (inverted to 1), so the final carry reduces to partial[WIDTH] | carry.
   // Carry-out (no borrow) is the "non-negative" test; unlike the sign bit it
   // stays correct when div == 0, which must produce an all-ones quotient.
   assign q_bit    = partial[WIDTH] | carry[WIDTH];
   assign rem_next = q_bit ? diff : partial[WIDTH-1:0];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder, the ripple cell shared with the array multiplier.
// Ports:
//   a, b, cin  in   operand bits and carry in
//   s          out  sum bit
//   cout       out  carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative restoring divider, one quotient bit per clock. Unsigned
//   WIDTH-bit dividend / divisor -> WIDTH-bit quotient and remainder.
//
//   Timeline (E0 = edge that accepts i_start):
//     E0          latch operands, R=0, cnt=WIDTH-1, go CALC
//     E1..EW      one div_step per edge; last step moves to DONE
//     EW+1        results and o_done registered, back to IDLE
//   o_busy is a registered copy of "state != IDLE", so it is high from E1
//   through the o_done cycle. A start presented during the o_done cycle is
//   accepted (state is already IDLE), giving WIDTH+2 cycles per operation.
//
// Ports:
//   i_clk          in   1      clock, rising edge
//   i_rst_n        in   1      asynchronous active-low reset
//   i_start        in   1      request, sampled only in IDLE
//   i_dividend     in   WIDTH  dividend, captured on accept
//   i_divisor      in   WIDTH  divisor, captured on accept
//   o_busy         out  1      operation in progress
//   o_done         out  1      one-cycle pulse, results valid
//   o_quotient     out  WIDTH  quotient, held until next o_done
//   o_remainder    out  WIDTH  remainder, held until next o_done
//   o_div_by_zero  out  1      divisor was zero for this result
// -----------------------------------------------------------------------------
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   div_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] q_reg;   // dividend shifts out the top, quotient in the bottom
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] r_next;
   logic             q_bit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (r_reg),
      .q_msb    (q_reg[WIDTH-1]),
      .div      (d_reg),
      .rem_next (r_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         q_reg         <= '0;
         r_reg         <= '0;
         d_reg         <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_quotient    <= '0;
         o_remainder   <= '0;
         o_div_by_zero <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_busy <= (state != IDLE);
         case (state)
            IDLE: begin
               if (i_start) begin
                  q_reg <= i_dividend;
                  d_reg <= i_divisor;
                  r_reg <= '0;
                  cnt   <= CNT_INIT;
                  state <= CALC;
               end
            end
            CALC: begin
               q_reg <= {q_reg[WIDTH-2:0], q_bit};
               r_reg <= r_next;
               cnt   <= cnt - CNT_ONE;
               if (cnt == '0) state <= DONE;
            end
            DONE: begin
               o_quotient    <= q_reg;
               o_remainder   <= r_reg;
               o_div_by_zero <= (d_reg == '0);
               o_done        <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   // WIDTH=4 instance
   logic       start4;
   logic [3:0] a4, b4, q4, r4;
   logic       busy4, done4, dbz4;
   // WIDTH=6 instance
   logic       start6;
   logic [5:0] a6, b6, q6, r6;
   logic       busy6, done6, dbz6;

   int n_vec = 0;
   int n_err = 0;

   seq_divider #(.WIDTH(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start4),
      .i_dividend(a4), .i_divisor(b4),
      .o_busy(busy4), .o_done(done4), .o_quotient(q4),
      .o_remainder(r4), .o_div_by_zero(dbz4)
   );

   seq_divider #(.WIDTH(6)) dut6 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start6),
      .i_dividend(a6), .i_divisor(b6),
      .o_busy(busy6), .o_done(done6), .o_quotient(q6),
      .o_remainder(r6), .o_div_by_zero(dbz6)
   );

   // Reference: plain integer division; divide-by-zero gives all ones / dividend.
   task automatic ref_div(input int w, input int a, input int b, output int q, output int r);
      if (b == 0) begin
         q = (1 << w) - 1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // All tasks start and end in the low phase just after a negedge.
   task automatic launch4(input logic [3:0] a, input logic [3:0] b);
      a4 = a; b4 = b; start4 = 1'b1;
   endtask

   task automatic launch6(input logic [5:0] a, input logic [5:0] b);
      a6 = a; b6 = b; start6 = 1'b1;
   endtask

   // Counts negedges since the accept edge until o_done is seen (bounded).
   // With noise, start and operands toggle randomly while the DUT is busy.
   task automatic wait_done4(input bit noise, input int lat0, output int lat);
      lat = lat0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (done4 === 1'b1) begin
            start4 = 1'b0;
            return;
         end
         if (noise) begin
            start4 = 1'($urandom_range(0, 1));
            a4 = 4'($urandom);
            b4 = 4'($urandom);
         end else begin
            start4 = 1'b0;
         end
      end
      start4 = 1'b0;
   endtask

   task automatic wait_done6(input bit noise, input int lat0, output int lat);
      lat = lat0;
      while (lat < 24) begin
         @(negedge clk);
         lat++;
         if (done6 === 1'b1) begin
            start6 = 1'b0;
            return;
         end
         if (noise) begin
            start6 = 1'($urandom_range(0, 1));
            a6 = 6'($urandom);
            b6 = 6'($urandom);
         end else begin
            start6 = 1'b0;
         end
      end
      start6 = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      start4 = 1'b0; a4 = '0; b4 = '0;
      start6 = 1'b0; a6 = '0; b6 = '0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if ({q4, r4, dbz4, busy4, done4} !== 11'd0) begin
         n_err++;
         $display("FAIL reset4: got q=%h r=%h dbz=%b busy=%b done=%b, want all 0", q4, r4, dbz4, busy4, done4);
      end
      n_vec++;
      if ({q6, r6, dbz6, busy6, done6} !== 15'd0) begin
         n_err++;
         $display("FAIL reset6: got q=%h r=%h dbz=%b busy=%b done=%b, want all 0", q6, r6, dbz6, busy6, done6);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_op4(input string name, input int lat, input logic [3:0] eq,
                            input logic [3:0] er, input logic edbz);
      n_vec++;
      if (q4 !== eq || r4 !== er || dbz4 !== edbz || lat != 6) begin
         n_err++;
         $display("FAIL %s: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=%b lat=6",
                  name, q4, r4, dbz4, lat, eq, er, edbz);
      end
   endtask

   task automatic test_basic;
      int lat;
      launch4(4'd13, 4'd4);
      wait_done4(1'b0, 0, lat);
      check_op4("basic_13_4", lat, 4'd3, 4'd1, 1'b0);
      n_vec++;
      if (busy4 !== 1'b1) begin
         n_err++;
         $display("FAIL busy_in_done: got %b, want 1", busy4);
      end
      @(negedge clk);
      n_vec++;
      if (done4 !== 1'b0 || busy4 !== 1'b0 || q4 !== 4'd3) begin
         n_err++;
         $display("FAIL done_width: got done=%b busy=%b q=%0d, want done=0 busy=0 q=3", done4, busy4, q4);
      end
   endtask

   task automatic test_div_zero;
      int lat;
      launch4(4'd7, 4'd0);
      wait_done4(1'b0, 0, lat);
      check_op4("div0_7_0", lat, 4'hF, 4'd7, 1'b1);
      launch4(4'd15, 4'd1);
      wait_done4(1'b0, 0, lat);
      check_op4("div_15_1", lat, 4'd15, 4'd0, 1'b0);
   endtask

   task automatic test_small;
      int lat;
      launch4(4'd3, 4'd9);
      wait_done4(1'b0, 0, lat);
      check_op4("small_3_9", lat, 4'd0, 4'd3, 1'b0);
      launch4(4'd0, 4'd5);
      wait_done4(1'b0, 0, lat);
      check_op4("zero_0_5", lat, 4'd0, 4'd0, 1'b0);
   endtask

   task automatic test_start_while_busy;
      int lat;
      int extra;
      launch4(4'd13, 4'd4);
      @(negedge clk); start4 = 1'b0;
      @(negedge clk); start4 = 1'b1; a4 = 4'd2; b4 = 4'd1;
      wait_done4(1'b0, 2, lat);
      check_op4("busy_start", lat, 4'd3, 4'd1, 1'b0);
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done4 === 1'b1) extra++;
      end
      n_vec++;
      if (extra != 0 || q4 !== 4'd3) begin
         n_err++;
         $display("FAIL busy_single_done: got extra_done=%0d q=%0d, want 0 and 3", extra, q4);
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      int seen;
      launch4(4'd13, 4'd4);
      wait_done4(1'b0, 0, lat);
      launch4(4'd15, 4'd2);
      @(negedge clk); start4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({q4, r4, dbz4, busy4, done4} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_mid: got q=%0d r=%0d dbz=%b busy=%b done=%b, want all 0", q4, r4, dbz4, busy4, done4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done4 === 1'b1 || busy4 === 1'b1) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL reset_abort: got %0d cycles with done/busy, want 0", seen);
      end
      launch4(4'd9, 4'd2);
      wait_done4(1'b0, 0, lat);
      check_op4("after_reset_9_2", lat, 4'd4, 4'd1, 1'b0);
   endtask

   task automatic test_random;
      int lat, eq, er, a, b;
      for (int k = 0; k < 40; k++) begin
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         ref_div(4, a, b, eq, er);
         launch4(4'(a), 4'(b));
         wait_done4(1'b1, 0, lat);
         check_op4("random", lat, 4'(eq), 4'(er), b == 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   // Each new start is presented in the o_done cycle: WIDTH+2 cycles per op.
   task automatic test_back_to_back4;
      int lat, eq, er;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ref_div(4, a, b, eq, er);
            launch4(4'(a), 4'(b));
            wait_done4(1'b1, 0, lat);
            n_vec++;
            if (q4 !== 4'(eq) || r4 !== 4'(er) || dbz4 !== (b == 0) || lat != 6) begin
               n_err++;
               $display("FAIL exh4 %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=%b lat=6",
                        a, b, q4, r4, dbz4, lat, eq, er, b == 0);
            end
         end
      end
   endtask

   task automatic test_back_to_back6;
      int lat, eq, er;
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            ref_div(6, a, b, eq, er);
            launch6(6'(a), 6'(b));
            wait_done6(1'b1, 0, lat);
            n_vec++;
            if (q6 !== 6'(eq) || r6 !== 6'(er) || dbz6 !== (b == 0) || lat != 8) begin
               n_err++;
               $display("FAIL exh6 %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=%0d dbz=%b lat=8",
                        a, b, q6, r6, dbz6, lat, eq, er, b == 0);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_div_zero;
      test_small;
      test_start_while_busy;
      test_reset_mid;
      test_random;
      test_back_to_back4;
      test_back_to_back6;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
